// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
//   Shares one W x W multiplier unit (start / per-job reset / DONE control
//   interface) among N_REQ requesters. Round-robin arbitration picks a
//   requester, its operands are latched and issued to the unit, and the
//   product (or a timeout error) is returned to that requester as a
//   one-cycle pulse. A watchdog aborts jobs whose DONE never arrives.
//
// Ports
//   clk        clock
//   RESET      asynchronous, active-high reset
//   req        per-requester request level
//   op_x/op_y  packed operands, requester i at [i*W +: W]
//   gnt        one-hot grant, held for the whole job
//   rsp_valid  one-cycle pulse to the served requester
//   rsp_data   product; held after the pulse until overwritten
//   rsp_err    high with rsp_valid when the job timed out
//   busy       high whenever the sequencer is not idle
//   mul_start  one-cycle start pulse to the unit
//   mul_x/y    operands to the unit
//   mul_rst    one-cycle per-job reset to the unit
//   mul_done   unit DONE level (stays high until the unit is reset)
//   mul_res    unit product
// All outputs are registered.
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
   parameter int N_REQ   = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 32
) (
   input  logic               clk,
   input  logic               RESET,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] op_x,
   input  logic [N_REQ*W-1:0] op_y,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   rsp_valid,
   output logic [2*W-1:0]     rsp_data,
   output logic               rsp_err,
   output logic               busy,
   output logic               mul_start,
   output logic [W-1:0]       mul_x,
   output logic [W-1:0]       mul_y,
   output logic               mul_rst,
   input  logic               mul_done,
   input  logic [2*W-1:0]     mul_res
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int WD_W  = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   win_q, win_d;
   logic [WD_W-1:0]    wdog_q, wdog_d;

   logic [N_REQ-1:0]   gnt_d, rsp_valid_d;
   logic [2*W-1:0]     rsp_data_d;
   logic               rsp_err_d, busy_d, mul_start_d, mul_rst_d;
   logic [W-1:0]       mul_x_d, mul_y_d;

   logic [PTR_W-1:0]   arb_win;
   logic               arb_found;

   // Round-robin pick: first asserted request at or after rr_ptr, wrapping.
   always_comb begin
      arb_found = 1'b0;
      arb_win   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!arb_found && req[(int'(rr_ptr_q) + k) % N_REQ]) begin
            arb_found = 1'b1;
            arb_win   = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      win_d       = win_q;
      wdog_d      = wdog_q;
      gnt_d       = gnt;
      rsp_valid_d = rsp_valid;
      rsp_data_d  = rsp_data;
      rsp_err_d   = rsp_err;
      mul_start_d = mul_start;
      mul_x_d     = mul_x;
      mul_y_d     = mul_y;
      mul_rst_d   = mul_rst;

      unique case (state_q)
         S_IDLE: begin
            // A DONE still high from the previous job blocks a new issue.
            if (arb_found && !mul_done) begin
               gnt_d          = '0;
               gnt_d[arb_win] = 1'b1;
               win_d          = arb_win;
               mul_x_d        = op_x[arb_win*W +: W];
               mul_y_d        = op_y[arb_win*W +: W];
               mul_start_d    = 1'b1;
               state_d        = S_ISSUE;
            end
         end

         S_ISSUE: begin
            mul_start_d = 1'b0;
            wdog_d      = '0;
            state_d     = S_WAIT;
         end

         S_WAIT: begin
            // DONE is tested first so it wins over a coincident timeout.
            if (mul_done) begin
               rsp_data_d         = mul_res;
               rsp_valid_d        = '0;
               rsp_valid_d[win_q] = 1'b1;
               rsp_err_d          = 1'b0;
               mul_rst_d          = 1'b1;
               gnt_d              = '0;
               state_d            = S_RESP;
            end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
               rsp_data_d         = '0;
               rsp_valid_d        = '0;
               rsp_valid_d[win_q] = 1'b1;
               rsp_err_d          = 1'b1;
               mul_rst_d          = 1'b1;
               gnt_d              = '0;
               state_d            = S_RESP;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end

         S_RESP: begin
            rsp_valid_d = '0;
            rsp_err_d   = 1'b0;
            mul_rst_d   = 1'b0;
            rr_ptr_d    = (win_q == PTR_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
            state_d     = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         rr_ptr_q  <= '0;
         win_q     <= '0;
         wdog_q    <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         mul_start <= 1'b0;
         mul_x     <= '0;
         mul_y     <= '0;
         mul_rst   <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         win_q     <= win_d;
         wdog_q    <= wdog_d;
         gnt       <= gnt_d;
         rsp_valid <= rsp_valid_d;
         rsp_data  <= rsp_data_d;
         rsp_err   <= rsp_err_d;
         busy      <= busy_d;
         mul_start <= mul_start_d;
         mul_x     <= mul_x_d;
         mul_y     <= mul_y_d;
         mul_rst   <= mul_rst_d;
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_share_arbiter
//   Directed bench for mult_share_arbiter with a behavioural multiplier unit
//   that raises DONE a fixed number of cycles after start (or never).
// ---------------------------------------------------------------------------
module tb_mult_share_arbiter;

   localparam int N_REQ   = 4;
   localparam int W       = 8;
   localparam int TIMEOUT = 32;
   localparam int DELAY   = 14;

   logic               clk = 1'b0;
   logic               RESET;
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] op_x, op_y;
   logic [N_REQ-1:0]   gnt, rsp_valid;
   logic [2*W-1:0]     rsp_data;
   logic               rsp_err, busy, mul_start, mul_rst, mul_done;
   logic [W-1:0]       mul_x, mul_y;
   logic [2*W-1:0]     mul_res;

   logic               force_done, never_done;

   always #5 clk = ~clk;

   mult_share_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .RESET     (RESET),
      .req       (req),
      .op_x      (op_x),
      .op_y      (op_y),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mul_start (mul_start),
      .mul_x     (mul_x),
      .mul_y     (mul_y),
      .mul_rst   (mul_rst),
      .mul_done  (mul_done),
      .mul_res   (mul_res)
   );

   // Multiplier unit model: DONE rises DELAY edges after it sees start.
   logic        model_done;
   logic [15:0] model_res;
   int          model_cnt;

   always @(posedge clk or posedge RESET) begin
      if (RESET) begin
         model_done <= 1'b0;
         model_cnt  <= 0;
         model_res  <= '0;
      end else if (mul_rst) begin
         model_done <= 1'b0;
         model_cnt  <= 0;
      end else if (mul_start) begin
         model_res <= 16'(mul_x) * 16'(mul_y);
         model_cnt <= never_done ? 0 : DELAY;
      end else if (model_cnt != 0) begin
         model_cnt <= model_cnt - 1;
         if (model_cnt == 1) model_done <= 1'b1;
      end
   end

   assign mul_done = model_done | force_done;
   assign mul_res  = model_res;

   // Monitor, sampled on the falling edge.
   int               start_cnt = 0;
   int               rst_cnt   = 0;
   int               oh_err    = 0;
   int               g_n       = 0;
   int               grant_log [64];
   logic [N_REQ-1:0] prev_gnt  = '0;

   always @(negedge clk) begin
      if (mul_start) start_cnt++;
      if (mul_rst) rst_cnt++;
      if (!$onehot0(gnt)) oh_err++;
      if (gnt != '0 && prev_gnt == '0 && g_n < 64) begin
         for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) grant_log[g_n] = i;
         g_n++;
      end
      prev_gnt = gnt;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
      op_x[i*W +: W] = x;
      op_y[i*W +: W] = y;
   endtask

   task automatic wait_start(input int budget, output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!mul_start && cyc < budget);
   endtask

   task automatic wait_rsp(input int budget, output logic [N_REQ-1:0] v,
                           output logic [15:0] d, output logic e, output int cyc);
      cyc = 0;
      v   = '0;
      d   = '0;
      e   = 1'b0;
      while (cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid != '0) begin
            v = rsp_valid;
            d = rsp_data;
            e = rsp_err;
            break;
         end
      end
   endtask

   initial begin
      logic [N_REQ-1:0] v;
      logic [15:0]      d;
      logic             e;
      int               cyc, s0, r0, g0, idx;

      RESET = 1'b1; req = '0; op_x = '0; op_y = '0;
      force_done = 1'b0; never_done = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ctrl", {gnt, rsp_valid, rsp_err, busy, mul_start, mul_rst}, '0);
      check("rst_data", {rsp_data, mul_x, mul_y}, '0);
      RESET = 1'b0;
      repeat (2) @(negedge clk);

      // T1: single job, FF*FF
      set_ops(0, 8'hFF, 8'hFF);
      s0 = start_cnt; r0 = rst_cnt;
      req = 4'b0001;
      wait_start(10, cyc);
      check("t1_start_lat", cyc, 1);
      check("t1_gnt", gnt, 4'b0001);
      check("t1_mul_xy", {mul_x, mul_y}, 16'hFFFF);
      check("t1_busy", busy, 1);
      wait_rsp(40, v, d, e, cyc);
      req = '0;
      check("t1_valid", v, 4'b0001);
      check("t1_data", d, 16'hFE01);
      check("t1_err", e, 0);
      check("t1_rsp_lat", cyc, DELAY + 2);
      check("t1_mul_rst", mul_rst, 1);
      check("t1_gnt_clr", gnt, 0);
      @(negedge clk);
      check("t1_pulse_end", {rsp_valid, mul_rst}, 0);
      check("t1_data_held", rsp_data, 16'hFE01);
      check("t1_idle", busy, 0);
      repeat (3) @(negedge clk);
      check("t1_start_cnt", start_cnt - s0, 1);
      check("t1_rst_cnt", rst_cnt - r0, 1);

      // T3: unit never answers -> timeout
      never_done = 1'b1;
      set_ops(2, 8'h12, 8'h34);
      r0 = rst_cnt;
      req = 4'b0100;
      wait_start(10, cyc);
      check("t3_gnt", gnt, 4'b0100);
      wait_rsp(80, v, d, e, cyc);
      req = '0;
      check("t3_valid", v, 4'b0100);
      check("t3_err", e, 1);
      check("t3_data", d, 0);
      check("t3_lat", cyc, TIMEOUT + 1);
      check("t3_mul_rst", mul_rst, 1);
      @(negedge clk);
      check("t3_pulse_end", {rsp_valid, rsp_err, mul_rst}, 0);
      never_done = 1'b0;
      repeat (3) @(negedge clk);
      check("t3_rst_cnt", rst_cnt - r0, 1);

      // Fresh pointer for the round-robin sequence
      RESET = 1'b1;
      @(negedge clk);
      RESET = 1'b0;
      @(negedge clk);

      // T2: all requesting, operands i*3 and i+5
      for (int i = 0; i < N_REQ; i++) set_ops(i, W'(i * 3), W'(i + 5));
      g0 = g_n;
      req = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         idx = j % N_REQ;
         wait_rsp(60, v, d, e, cyc);
         check($sformatf("t2_valid%0d", j), v, 32'(1) << idx);
         check($sformatf("t2_data%0d", j), d, 32'((idx * 3) * (idx + 5)));
      end
      req = '0;
      for (int j = 0; j < 5; j++)
         check($sformatf("t2_order%0d", j), grant_log[g0 + j], j % N_REQ);
      repeat (3) @(negedge clk);

      // T6: req0 dropped and op_x0 changed mid-job
      set_ops(0, 8'd200, 8'd150);
      req = 4'b0001;
      wait_start(10, cyc);
      check("t6_gnt", gnt, 4'b0001);
      repeat (4) @(negedge clk);
      req = '0;
      op_x[7:0] = 8'h01;
      @(negedge clk);
      check("t6_mul_x_latched", mul_x, 8'd200);
      wait_rsp(40, v, d, e, cyc);
      check("t6_valid", v, 4'b0001);
      check("t6_data", d, 16'h7530);
      repeat (3) @(negedge clk);

      // T4: stale DONE blocks issue
      force_done = 1'b1;
      set_ops(1, 8'hA5, 8'h3C);
      s0 = start_cnt;
      req = 4'b0010;
      repeat (6) @(negedge clk);
      check("t4_no_start", start_cnt - s0, 0);
      check("t4_no_gnt", {gnt, busy}, 0);
      force_done = 1'b0;
      wait_start(5, cyc);
      check("t4_start_lat", cyc, 1);
      check("t4_gnt", gnt, 4'b0010);
      wait_rsp(40, v, d, e, cyc);
      req = '0;
      check("t4_valid", v, 4'b0010);
      check("t4_data", d, 16'h26AC);
      repeat (3) @(negedge clk);

      // T5: RESET 5 cycles into WAIT, pointer sits at 2 beforehand
      set_ops(1, 8'h0B, 8'h0D);
      set_ops(3, 8'h07, 8'h09);
      req = 4'b0010;
      wait_start(10, cyc);
      check("t5_gnt", gnt, 4'b0010);
      repeat (6) @(negedge clk);
      #2 RESET = 1'b1;
      #1;
      check("t5_async_ctrl", {gnt, rsp_valid, rsp_err, busy, mul_start, mul_rst}, '0);
      check("t5_async_data", {rsp_data, mul_x, mul_y}, '0);
      req = 4'b1010;
      @(negedge clk);
      RESET = 1'b0;
      wait_start(10, cyc);
      check("t5_first_gnt", gnt, 4'b0010);
      wait_rsp(40, v, d, e, cyc);
      check("t5_valid1", v, 4'b0010);
      check("t5_data1", d, 16'h008F);
      wait_rsp(60, v, d, e, cyc);
      req = '0;
      check("t5_valid3", v, 4'b1000);
      check("t5_data3", d, 16'h003F);
      repeat (3) @(negedge clk);

      check("gnt_onehot", oh_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
